// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - RV32I branch resolution, fetch PC register and redirect/flush control
// Compare op encoding: 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 6..7 unknown.
module branch_pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            ex_valid_i,
    input  logic            jump_c_i,
    input  logic            branch_c_i,
    input  logic [2:0]      cmp_op_c_i,
    input  logic            jalr_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            imem_ready_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] pc_o,
    output logic            taken_o,
    output logic            redirect_o,
    output logic            flush_o,
    output logic            misaligned_o
);

    localparam logic [2:0] CMP_BEQ  = 3'd0;
    localparam logic [2:0] CMP_BNE  = 3'd1;
    localparam logic [2:0] CMP_BLT  = 3'd2;
    localparam logic [2:0] CMP_BGE  = 3'd3;
    localparam logic [2:0] CMP_BLTU = 3'd4;
    localparam logic [2:0] CMP_BGEU = 3'd5;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_FLUSH = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            mis_q, mis_d;

    logic            cmp_true;
    logic            eff_valid;
    logic            taken;
    logic            redirect;
    logic            misalign_hit;
    logic [XLEN-1:0] eff_tgt;

    always_comb begin
        cmp_true = 1'b0;
        case (cmp_op_c_i)
            CMP_BEQ:  cmp_true = (rs1_data_i == rs2_data_i);
            CMP_BNE:  cmp_true = (rs1_data_i != rs2_data_i);
            CMP_BLT:  cmp_true = ($signed(rs1_data_i) <  $signed(rs2_data_i));
            CMP_BGE:  cmp_true = ($signed(rs1_data_i) >= $signed(rs2_data_i));
            CMP_BLTU: cmp_true = (rs1_data_i <  rs2_data_i);
            CMP_BGEU: cmp_true = (rs1_data_i >= rs2_data_i);
            default:  cmp_true = 1'b0;
        endcase
    end

    // Wrong-path and trapped instructions never resolve; jump overrides the compare.
    assign eff_valid    = ex_valid_i && (state_q == ST_FETCH) && !rst_i;
    assign taken        = eff_valid && !stall_i && (jump_c_i || (branch_c_i && cmp_true));
    assign eff_tgt      = jalr_i ? {target_i[XLEN-1:1], 1'b0} : target_i;
    assign misalign_hit = taken && eff_tgt[1];
    assign redirect     = taken && !eff_tgt[1];

    assign imem_req_o   = !rst_i && (state_q != ST_TRAP);
    assign pc_o         = pc_q;
    assign taken_o      = taken;
    assign redirect_o   = redirect;
    assign flush_o      = taken || (state_q == ST_FLUSH);
    assign misaligned_o = mis_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        pc_d    = pc_q;
        if (!stall_i) begin
            case (state_q)
                ST_FETCH: begin
                    if (misalign_hit) begin
                        state_d = ST_TRAP;
                        mis_d   = 1'b1;
                    end else if (redirect) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end
                end
                ST_FLUSH: begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
            // A misaligned take holds the PC on the faulting fetch address.
            if (redirect) begin
                pc_d = eff_tgt;
            end else if (imem_req_o && imem_ready_i && !taken) begin
                pc_d = pc_q + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_FETCH;
            cnt_q   <= 3'd0;
            pc_q    <= RESET_PC;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
        end
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - directed and randomized checks of branch_pc_unit against a cycle model
module tb_branch_pc_unit;

    localparam int FC = 2;
    localparam logic [2:0] BEQ  = 3'd0;
    localparam logic [2:0] BNE  = 3'd1;
    localparam logic [2:0] BLT  = 3'd2;
    localparam logic [2:0] BGE  = 3'd3;
    localparam logic [2:0] BLTU = 3'd4;
    localparam logic [2:0] BGEU = 3'd5;
    localparam logic [2:0] UNK  = 3'd7;

    logic        clk, rst, stall, ex_valid, jump, branch, jalr, ready;
    logic [2:0]  cmp_op;
    logic [31:0] rs1, rs2, target;
    logic        req, taken, redirect, flush, mis;
    logic [31:0] pc;
    logic [36:0] obs;

    int n_cmp;
    int n_fail;

    // Reference model state: step counts unstalled cycles since reset.
    logic [31:0] m_pc;
    logic        m_trap, m_mis;
    longint      m_step, m_flush_until;

    branch_pc_unit #(
        .XLEN(32),
        .RESET_PC(32'h0000_0000),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .stall_i(stall),
        .ex_valid_i(ex_valid),
        .jump_c_i(jump),
        .branch_c_i(branch),
        .cmp_op_c_i(cmp_op),
        .jalr_i(jalr),
        .rs1_data_i(rs1),
        .rs2_data_i(rs2),
        .target_i(target),
        .imem_ready_i(ready),
        .imem_req_o(req),
        .pc_o(pc),
        .taken_o(taken),
        .redirect_o(redirect),
        .flush_o(flush),
        .misaligned_o(mis)
    );

    assign obs = {pc, req, taken, redirect, flush, mis};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle;
        stall = 0; ex_valid = 0; jump = 0; branch = 0; jalr = 0; ready = 1;
        cmp_op = BEQ; rs1 = 0; rs2 = 0; target = 0;
    endtask

    task automatic do_reset;
        idle();
        rst = 1;
        cyc();
        rst = 0;
    endtask

    function automatic logic model_cmp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a; sb = b;
        case (op)
            BEQ:  return a == b;
            BNE:  return a != b;
            BLT:  return sa < sb;
            BGE:  return sa >= sb;
            BLTU: return a < b;
            BGEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset;
        m_pc = 32'h0; m_trap = 0; m_mis = 0; m_step = 0; m_flush_until = -1;
    endtask

    task automatic test_reset;
        rst = 1; idle();
        #2;
        n_cmp++;
        if (obs !== {32'h0, 5'b00000}) begin
            n_fail++; $display("FAIL reset_state got %h want %h", obs, {32'h0, 5'b00000});
        end
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (obs !== {32'(4 * i), 5'b10000}) begin
                n_fail++; $display("FAIL seq_fetch_%0d got %h want %h", i, obs, {32'(4 * i), 5'b10000});
            end
            cyc();
        end
    endtask

    task automatic test_beq;
        ex_valid = 1; branch = 1; cmp_op = BEQ; rs1 = 5; rs2 = 5; target = 32'h40;
        #1; n_cmp++;
        if (obs !== {32'h10, 5'b11110}) begin
            n_fail++; $display("FAIL beq_resolve got %h want %h", obs, {32'h10, 5'b11110});
        end
        cyc();
        jump = 1; target = 32'h80;
        #1; n_cmp++;
        if (obs !== {32'h40, 5'b10010}) begin
            n_fail++; $display("FAIL beq_t1_ignored got %h want %h", obs, {32'h40, 5'b10010});
        end
        cyc();
        #1; n_cmp++;
        if (obs !== {32'h44, 5'b10010}) begin
            n_fail++; $display("FAIL beq_t2 got %h want %h", obs, {32'h44, 5'b10010});
        end
        cyc();
        idle();
        #1; n_cmp++;
        if (obs !== {32'h48, 5'b10000}) begin
            n_fail++; $display("FAIL beq_t3_end got %h want %h", obs, {32'h48, 5'b10000});
        end
    endtask

    task automatic test_compare;
        logic [2:0] ops [8] = '{BLT, BLTU, BGEU, BGE, BEQ, BNE, UNK, BEQ};
        logic       jmp [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        logic       exp [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        logic [31:0] tgt;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            tgt = 32'h200 + 32'(k * 16);
            ex_valid = 1; branch = 1; jump = jmp[k]; cmp_op = ops[k];
            rs1 = 32'hFFFF_FFFF; rs2 = 32'h1; target = tgt;
            #1; n_cmp++;
            if ({taken, redirect, flush} !== {3{exp[k]}}) begin
                n_fail++; $display("FAIL cmp_case_%0d got %b want %b", k, {taken, redirect, flush}, {3{exp[k]}});
            end
            cyc();
            idle();
            if (exp[k]) begin
                #1; n_cmp++;
                if (pc !== tgt) begin
                    n_fail++; $display("FAIL cmp_target_%0d got %h want %h", k, pc, tgt);
                end
            end
            repeat (FC + 1) cyc();
        end
    endtask

    task automatic test_jalr_misalign;
        do_reset();
        ex_valid = 1; jump = 1; jalr = 1; target = 32'h101;
        #1; n_cmp++;
        if ({taken, redirect, flush, mis} !== 4'b1110) begin
            n_fail++; $display("FAIL jalr_aligned got %b want %b", {taken, redirect, flush, mis}, 4'b1110);
        end
        cyc();
        idle();
        #1; n_cmp++;
        if (pc !== 32'h100) begin
            n_fail++; $display("FAIL jalr_clear_bit0 got %h want %h", pc, 32'h100);
        end
        cyc(); cyc();
        ex_valid = 1; jump = 1; jalr = 1; target = 32'h103;
        #1; n_cmp++;
        if (obs !== {32'h108, 5'b11010}) begin
            n_fail++; $display("FAIL misalign_resolve got %h want %h", obs, {32'h108, 5'b11010});
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            #1; n_cmp++;
            if (obs !== {32'h108, 5'b00001}) begin
                n_fail++; $display("FAIL trap_hold_%0d got %h want %h", i, obs, {32'h108, 5'b00001});
            end
        end
        rst = 1;
        #1; n_cmp++;
        if (obs !== {32'h0, 5'b00000}) begin
            n_fail++; $display("FAIL trap_reset got %h want %h", obs, {32'h0, 5'b00000});
        end
        cyc();
        rst = 0; idle();
    endtask

    task automatic test_stall;
        do_reset();
        stall = 1; ex_valid = 1; branch = 1; cmp_op = BNE; rs1 = 1; rs2 = 2; target = 32'h80;
        for (int i = 0; i < 3; i++) begin
            #1; n_cmp++;
            if (obs !== {32'h0, 5'b10000}) begin
                n_fail++; $display("FAIL stall_hold_%0d got %h want %h", i, obs, {32'h0, 5'b10000});
            end
            cyc();
        end
        stall = 0;
        #1; n_cmp++;
        if (obs !== {32'h0, 5'b11110}) begin
            n_fail++; $display("FAIL stall_release got %h want %h", obs, {32'h0, 5'b11110});
        end
        cyc();
        idle(); stall = 1;
        for (int i = 0; i < 2; i++) begin
            #1; n_cmp++;
            if (obs !== {32'h80, 5'b10010}) begin
                n_fail++; $display("FAIL stall_in_flush_%0d got %h want %h", i, obs, {32'h80, 5'b10010});
            end
            cyc();
        end
        stall = 0;
        #1; n_cmp++;
        if (obs !== {32'h80, 5'b10010}) begin
            n_fail++; $display("FAIL flush_resume1 got %h want %h", obs, {32'h80, 5'b10010});
        end
        cyc();
        #1; n_cmp++;
        if (obs !== {32'h84, 5'b10010}) begin
            n_fail++; $display("FAIL flush_resume2 got %h want %h", obs, {32'h84, 5'b10010});
        end
        cyc();
        #1; n_cmp++;
        if (obs !== {32'h88, 5'b10000}) begin
            n_fail++; $display("FAIL flush_done got %h want %h", obs, {32'h88, 5'b10000});
        end
    endtask

    task automatic test_imem_wait;
        do_reset();
        ready = 0;
        cyc(); cyc();
        #1; n_cmp++;
        if (obs !== {32'h0, 5'b10000}) begin
            n_fail++; $display("FAIL imem_wait_hold got %h want %h", obs, {32'h0, 5'b10000});
        end
        cyc();
        ex_valid = 1; jump = 1; target = 32'h20;
        #1; n_cmp++;
        if (obs !== {32'h0, 5'b11110}) begin
            n_fail++; $display("FAIL wait_redirect got %h want %h", obs, {32'h0, 5'b11110});
        end
        cyc();
        ex_valid = 0; jump = 0;
        #1; n_cmp++;
        if (obs !== {32'h20, 5'b10010}) begin
            n_fail++; $display("FAIL wait_redirect_addr got %h want %h", obs, {32'h20, 5'b10010});
        end
        cyc();
        idle();
    endtask

    task automatic test_reset_flush_wrap;
        do_reset();
        ex_valid = 1; jump = 1; target = 32'hFFFF_FFFC;
        #1; cyc();
        idle();
        #1; n_cmp++;
        if (obs !== {32'hFFFF_FFFC, 5'b10010}) begin
            n_fail++; $display("FAIL wrap_target got %h want %h", obs, {32'hFFFF_FFFC, 5'b10010});
        end
        cyc();
        #1; n_cmp++;
        if (obs !== {32'h0, 5'b10010}) begin
            n_fail++; $display("FAIL wrap_zero got %h want %h", obs, {32'h0, 5'b10010});
        end
        cyc(); cyc();
        ex_valid = 1; jump = 1; target = 32'h300;
        #1; cyc();
        idle();
        #1; n_cmp++;
        if (obs !== {32'h300, 5'b10010}) begin
            n_fail++; $display("FAIL flush1_before_rst got %h want %h", obs, {32'h300, 5'b10010});
        end
        #2 rst = 1;
        #1; n_cmp++;
        if (obs !== {32'h0, 5'b00000}) begin
            n_fail++; $display("FAIL async_rst_flush got %h want %h", obs, {32'h0, 5'b00000});
        end
        @(negedge clk);
        rst = 0;
        #1; n_cmp++;
        if (obs !== {32'h0, 5'b10000}) begin
            n_fail++; $display("FAIL post_rst got %h want %h", obs, {32'h0, 5'b10000});
        end
        cyc();
    endtask

    task automatic test_random;
        int trap_cycles;
        logic [31:0] tgt;
        logic in_flush, m_taken, m_redir, m_flush, m_req;
        logic [36:0] exp_v;
        do_reset();
        model_reset();
        trap_cycles = 0;
        for (int n = 0; n < 600; n++) begin
            if (trap_cycles > 2 || $urandom_range(63) == 0) begin
                do_reset();
                model_reset();
                trap_cycles = 0;
            end
            stall    = ($urandom_range(4) == 0);
            ex_valid = $urandom_range(1);
            jump     = ($urandom_range(5) == 0);
            branch   = ($urandom_range(2) == 0);
            jalr     = $urandom_range(1);
            cmp_op   = 3'($urandom_range(7));
            ready    = ($urandom_range(3) != 0);
            rs1      = $urandom_range(1) ? $urandom_range(3) : $urandom;
            rs2      = $urandom_range(1) ? $urandom_range(3) : $urandom;
            target   = $urandom;
            if ($urandom_range(3) != 0) target[1:0] = 2'b00;

            tgt      = jalr ? (target & 32'hFFFF_FFFE) : target;
            in_flush = (m_step <= m_flush_until);
            m_req    = !m_trap;
            m_taken  = ex_valid && !in_flush && !m_trap && !stall &&
                       (jump || (branch && model_cmp(cmp_op, rs1, rs2)));
            m_redir  = m_taken && !tgt[1];
            m_flush  = m_taken || in_flush;
            exp_v    = {m_pc, m_req, m_taken, m_redir, m_flush, m_mis};

            #1; n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL random_cycle_%0d got %h want %h", n, obs, exp_v);
            end

            if (!stall) begin
                if (m_taken && tgt[1]) begin
                    m_trap = 1; m_mis = 1;
                end else if (m_redir) begin
                    m_pc = tgt;
                    m_flush_until = m_step + FC;
                end else if (m_req && ready) begin
                    m_pc = m_pc + 32'd4;
                end
                m_step++;
            end
            if (m_trap) trap_cycles++;
            cyc();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_beq();
        test_compare();
        test_jalr_misalign();
        test_stall();
        test_imem_wait();
        test_reset_flush_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
